// File: rtl/cohort_mshr_arbiter_pkg.sv
// Shared types for the cohort MSHR arbiter: id width and the per-slot
// ownership record kept in the MSHR table.
package cohort_arb_pkg;
    localparam int MSHR_ID_W   = 8;
    localparam int SRC_IDX_W   = 4;
    localparam int ENTRY_TAG_W = 4;

    typedef struct packed {
        logic [SRC_IDX_W-1:0]   src;
        logic [ENTRY_TAG_W-1:0] tag;
    } mshr_entry_t;
endpackage

// File: rtl/cohort_mshr_arbiter_if.sv
// Consumer-side request/response bundle plus the downstream request/response
// path. master = arbiter side, slave = consumers/downstream side.
interface cohort_mshr_arbiter_if
    import cohort_arb_pkg::*;
#(
    parameter int SOURCE_NUM = 3,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4
);
    logic [SOURCE_NUM-1:0]        src_req_valid;
    logic [SOURCE_NUM-1:0]        src_req_ready;
    logic [SOURCE_NUM*ADDR_W-1:0] src_req_addr;
    logic [SOURCE_NUM*DATA_W-1:0] src_req_data;
    logic [SOURCE_NUM*TAG_W-1:0]  src_req_tag;
    logic                         sink_req_valid;
    logic                         sink_req_ready;
    logic [ADDR_W-1:0]            sink_req_addr;
    logic [DATA_W-1:0]            sink_req_data;
    logic [MSHR_ID_W-1:0]         sink_req_mshrid;
    logic                         sink_resp_valid;
    logic [MSHR_ID_W-1:0]         sink_resp_mshrid;
    logic [DATA_W-1:0]            sink_resp_data;
    logic [SOURCE_NUM-1:0]        src_resp_valid;
    logic [TAG_W-1:0]             src_resp_tag;
    logic [DATA_W-1:0]            src_resp_data;

    modport master (
        input  src_req_valid, src_req_addr, src_req_data, src_req_tag,
        output src_req_ready,
        output sink_req_valid, sink_req_addr, sink_req_data, sink_req_mshrid,
        input  sink_req_ready,
        input  sink_resp_valid, sink_resp_mshrid, sink_resp_data,
        output src_resp_valid, src_resp_tag, src_resp_data
    );

    modport slave (
        output src_req_valid, src_req_addr, src_req_data, src_req_tag,
        input  src_req_ready,
        input  sink_req_valid, sink_req_addr, sink_req_data, sink_req_mshrid,
        output sink_req_ready,
        output sink_resp_valid, sink_resp_mshrid, sink_resp_data,
        input  src_resp_valid, src_resp_tag, src_resp_data
    );
endinterface

// File: rtl/cohort_mshr_arbiter_wrr.sv
// Weighted round-robin grant: scans upward from ptr, the holder keeps the turn
// for up to max(weight,1) accepts or until it stops requesting.
module cohort_wrr_arbiter #(
    parameter int SOURCE_NUM = 3,
    parameter int WEIGHT_W   = 4,
    parameter int SRC_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SOURCE_NUM-1:0]        req_i,
    input  logic [SOURCE_NUM*WEIGHT_W-1:0] weight_i,
    input  logic                         accept_i,
    output logic [SOURCE_NUM-1:0]        grant_o,
    output logic [SRC_W-1:0]             grant_idx_o,
    output logic                         grant_any_o
);
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] turn_q, turn_d;
    logic [WEIGHT_W-1:0] weight_arr [SOURCE_NUM];
    logic [SOURCE_NUM-1:0] req_rot;
    logic [SRC_W-1:0]    offset;
    logic [SRC_W:0]      idx_sum;
    logic [WEIGHT_W-1:0] w_eff, turn_base;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        return (v == SRC_W'(SOURCE_NUM - 1)) ? '0 : v + SRC_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < SOURCE_NUM; gi++) begin : g_src
            assign weight_arr[gi] = weight_i[gi*WEIGHT_W +: WEIGHT_W];
            assign grant_o[gi]    = grant_any_o && (grant_idx_o == SRC_W'(gi));
        end
    endgenerate

    // Rotate so bit 0 is the source at ptr, then find the first requester.
    assign req_rot = SOURCE_NUM'({req_i, req_i} >> ptr_q);

    always_comb begin
        offset = '0;
        for (int k = SOURCE_NUM - 1; k >= 0; k--)
            if (req_rot[k]) offset = SRC_W'(k);
    end

    assign idx_sum     = {1'b0, ptr_q} + {1'b0, offset};
    assign grant_idx_o = (idx_sum >= (SRC_W+1)'(SOURCE_NUM)) ?
                         SRC_W'(idx_sum - (SRC_W+1)'(SOURCE_NUM)) : SRC_W'(idx_sum);
    assign grant_any_o = |req_i;

    assign w_eff     = (weight_arr[grant_idx_o] == '0) ? WEIGHT_W'(1) : weight_arr[grant_idx_o];
    assign turn_base = (grant_idx_o == ptr_q) ? turn_q : '0;

    always_comb begin
        ptr_d  = ptr_q;
        turn_d = turn_q;
        if (accept_i) begin
            if (turn_base + WEIGHT_W'(1) >= w_eff) begin
                ptr_d  = wrap_inc(grant_idx_o);
                turn_d = '0;
            end else begin
                ptr_d  = grant_idx_o;
                turn_d = turn_base + WEIGHT_W'(1);
            end
        end else if (turn_q != '0 && !req_i[ptr_q]) begin
            // Holder went idle or was disabled mid-turn: pass the turn on.
            ptr_d  = wrap_inc(ptr_q);
            turn_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            turn_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            turn_q <= turn_d;
        end
    end
endmodule

// File: rtl/cohort_mshr_arbiter.sv
// N-consumer request arbiter with a shared MSHR-id pool; responses are routed
// back to the issuing consumer through the id-indexed ownership table.
module cohort_mshr_arbiter
    import cohort_arb_pkg::*;
#(
    parameter int SOURCE_NUM = 3,
    parameter int MSHR_BASE  = 128,
    parameter int MSHR_NUM   = 16,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4,
    parameter int WEIGHT_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SOURCE_NUM-1:0]          src_en,
    input  logic [SOURCE_NUM*WEIGHT_W-1:0] src_weight,
    cohort_mshr_arbiter_if.master          bus,
    output logic [$clog2(MSHR_NUM):0]      outstanding,
    output logic                           err_stray
);
    localparam int SRC_W  = (SOURCE_NUM > 1) ? $clog2(SOURCE_NUM) : 1;
    localparam int SLOT_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
    localparam int CNT_W  = $clog2(MSHR_NUM) + 1;

    logic [ADDR_W-1:0] addr_arr [SOURCE_NUM];
    logic [DATA_W-1:0] data_arr [SOURCE_NUM];
    logic [TAG_W-1:0]  tag_arr  [SOURCE_NUM];

    logic [SOURCE_NUM-1:0] grant, resp_onehot;
    logic [SRC_W-1:0]      grant_idx;
    logic                  grant_any, stage_free, pool_avail, accept;
    logic [SLOT_W-1:0]     alloc_slot, resp_slot;
    logic [MSHR_ID_W:0]    resp_id_ext;
    logic                  resp_in_range, resp_hit;
    mshr_entry_t           resp_entry;

    logic                  stage_valid_q;
    logic [ADDR_W-1:0]     stage_addr_q;
    logic [DATA_W-1:0]     stage_data_q;
    logic [MSHR_ID_W-1:0]  stage_id_q;
    logic [MSHR_NUM-1:0]   free_q, free_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [SOURCE_NUM-1:0] resp_valid_q;
    logic [TAG_W-1:0]      resp_tag_q;
    logic [DATA_W-1:0]     resp_data_q;
    logic                  err_q;
    mshr_entry_t           table_q [MSHR_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < SOURCE_NUM; gi++) begin : g_src
            assign addr_arr[gi]    = bus.src_req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi]    = bus.src_req_data[gi*DATA_W +: DATA_W];
            assign tag_arr[gi]     = bus.src_req_tag[gi*TAG_W +: TAG_W];
            assign resp_onehot[gi] = (resp_entry.src == SRC_IDX_W'(gi));
        end
    endgenerate

    cohort_wrr_arbiter #(
        .SOURCE_NUM (SOURCE_NUM),
        .WEIGHT_W   (WEIGHT_W),
        .SRC_W      (SRC_W)
    ) u_wrr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (src_en & bus.src_req_valid),
        .weight_i    (src_weight),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign stage_free        = !stage_valid_q || bus.sink_req_ready;
    assign pool_avail        = |free_q;
    assign accept            = grant_any && stage_free && pool_avail;
    assign bus.src_req_ready = grant & {SOURCE_NUM{stage_free && pool_avail}};

    always_comb begin
        alloc_slot = '0;
        for (int k = MSHR_NUM - 1; k >= 0; k--)
            if (free_q[k]) alloc_slot = SLOT_W'(k);
    end

    // Response id must land inside the pool window and hit a busy slot.
    assign resp_id_ext   = {1'b0, bus.sink_resp_mshrid};
    assign resp_in_range = (resp_id_ext >= (MSHR_ID_W+1)'(MSHR_BASE)) &&
                           (resp_id_ext <  (MSHR_ID_W+1)'(MSHR_BASE + MSHR_NUM));
    assign resp_slot     = SLOT_W'(bus.sink_resp_mshrid - MSHR_ID_W'(MSHR_BASE));
    assign resp_hit      = bus.sink_resp_valid && resp_in_range && !free_q[resp_slot];
    assign resp_entry    = table_q[resp_slot];

    always_comb begin
        free_d        = free_q;
        outstanding_d = outstanding_q;
        if (accept)   free_d[alloc_slot] = 1'b0;
        if (resp_hit) free_d[resp_slot]  = 1'b1;
        case ({accept, resp_hit})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            stage_id_q    <= '0;
            free_q        <= '1;
            outstanding_q <= '0;
            resp_valid_q  <= '0;
            resp_tag_q    <= '0;
            resp_data_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            if (stage_free) begin
                stage_valid_q <= accept;
                if (accept) begin
                    stage_addr_q <= addr_arr[grant_idx];
                    stage_data_q <= data_arr[grant_idx];
                    stage_id_q   <= MSHR_ID_W'(MSHR_BASE) + MSHR_ID_W'(alloc_slot);
                end
            end
            free_q        <= free_d;
            outstanding_q <= outstanding_d;
            resp_valid_q  <= resp_hit ? resp_onehot : '0;
            if (resp_hit) begin
                resp_tag_q  <= TAG_W'(resp_entry.tag);
                resp_data_q <= bus.sink_resp_data;
            end
            err_q <= bus.sink_resp_valid && !resp_hit;
        end
    end

    // Table needs no reset: the free bitmap decides which entries are live.
    always_ff @(posedge clk) begin
        if (accept)
            table_q[alloc_slot] <= '{src: SRC_IDX_W'(grant_idx), tag: ENTRY_TAG_W'(tag_arr[grant_idx])};
    end

    assign bus.sink_req_valid  = stage_valid_q;
    assign bus.sink_req_addr   = stage_addr_q;
    assign bus.sink_req_data   = stage_data_q;
    assign bus.sink_req_mshrid = stage_id_q;
    assign bus.src_resp_valid  = resp_valid_q;
    assign bus.src_resp_tag    = resp_tag_q;
    assign bus.src_resp_data   = resp_data_q;
    assign outstanding         = outstanding_q;
    assign err_stray           = err_q;
endmodule
